// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue/decode stage for a small MIPS-style ALU. It turns the main-control op
// class (ALUOp_i) and the R-format function field (funct_i) into a 4-bit ALU
// operation code, and sequences multi-cycle MUL operations. Non-MUL
// instructions complete one cycle after issue. A MUL with MUL_LAT > 1 blocks
// further issue until it completes MUL_LAT cycles after issue.
//
// Parameters
//   MUL_LAT    MUL result latency in cycles (1..15)
//   CNT_W      latency counter width, 2**CNT_W > MUL_LAT
//
// Ports
//   clk_i      in   clock, rising-edge active
//   rst_i      in   asynchronous active-high reset
//   valid_i    in   instruction presented
//   ready_o    out  block can accept (high exactly in IDLE)
//   funct_i    in   [5:0] R-format function field
//   ALUOp_i    in   [2:0] main-control ALU op class
//   flush_i    in   synchronous flush; wins over issue and MUL completion
//   valid_o    out  ALUCtrl_o / JR_o valid this cycle
//   ALUCtrl_o  out  [3:0] ALU operation code, holds last issued value
//   JR_o       out  jump-register, only ever high together with valid_o
//   illegal_o  out  sticky undecodable-instruction flag
//
// Configuration
//   ALU_ISSUE_ILLEGAL_TRAP_EN  defined: illegal_o is a sticky flag that sets
//                              on an illegal issue and clears only on reset.
//                              undefined: illegal_o is tied to 0.
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [5:0] funct_i,
  input  logic [2:0] ALUOp_i,
  input  logic       flush_i,
  output logic       valid_o,
  output logic [3:0] ALUCtrl_o,
  output logic       JR_o,
  output logic       illegal_o
);

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  // ALU operation codes
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_SLLV = 4'b1100;
  localparam logic [3:0] OP_SLL  = 4'b1101;
  localparam logic [3:0] OP_LUI  = 4'b1111;

  // A single-cycle MUL takes the ordinary latency-1 path and never waits.
  localparam bit             MUL_MULTI = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic               jr_q, jr_d;

  logic [3:0]         dec_ctrl;
  logic               dec_jr;
  logic               dec_mul;
  logic               dec_illegal;
  logic               issue;

  assign ready_o = (state_q == IDLE);
  assign issue   = valid_i && ready_o && !flush_i;

  // ---------------------------------------------------------------------------
  // Decode. Anything unknown falls back to ADD without JR and is flagged.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    dec_ctrl    = OP_ADD;
    dec_jr      = 1'b0;
    dec_mul     = 1'b0;
    dec_illegal = 1'b0;
    case (ALUOp_i)
      3'b100: begin
        case (funct_i)
          6'd32:   dec_ctrl = OP_ADD;
          6'd34:   dec_ctrl = OP_SUB;
          6'd36:   dec_ctrl = OP_AND;
          6'd37:   dec_ctrl = OP_OR;
          6'd42:   dec_ctrl = OP_SLT;
          6'd43:   dec_ctrl = OP_SLTU;
          6'd0:    dec_ctrl = OP_SLL;
          6'd4:    dec_ctrl = OP_SLLV;
          6'd24: begin
            dec_ctrl = OP_MUL;
            dec_mul  = 1'b1;
          end
          6'd8: begin
            dec_ctrl = OP_ADD;
            dec_jr   = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      3'b000:  dec_ctrl = OP_ADD;
      3'b110:  dec_ctrl = OP_ADD;
      3'b101:  dec_ctrl = OP_OR;
      3'b111:  dec_ctrl = OP_LUI;
      3'b010:  dec_ctrl = OP_SUB;
      default: dec_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered outputs. valid/JR default low so they pulse for
  // exactly one cycle; ALUCtrl defaults to its held value.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    ctrl_d  = ctrl_q;
    jr_d    = 1'b0;
    if (flush_i) begin
      // Flush drops any input and abandons an in-flight MUL, even one that
      // would complete on this edge.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            ctrl_d = dec_ctrl;
            if (dec_mul && MUL_MULTI) begin
              state_d = MUL_WAIT;
              cnt_d   = MUL_LOAD;
            end else begin
              valid_d = 1'b1;
              jr_d    = dec_jr;
            end
          end
        end
        MUL_WAIT: begin
          cnt_d = cnt_q - CNT_ONE;
          // Counter reaching 1 means the result is available next cycle.
          if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= OP_ADD;
      jr_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      jr_q    <= jr_d;
    end
  end

  assign valid_o   = valid_q;
  assign ALUCtrl_o = ctrl_q;
  assign JR_o      = jr_q;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      illegal_q <= 1'b0;
    end else if (issue && dec_illegal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_o = illegal_q;
`else
  // Decode still computes the flag; it simply has no consumer in this build.
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
  assign illegal_o      = 1'b0;
`endif

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, MUL result latency in cycles; legal 1..15.
REQ-002 SHALL have parameter CNT_W, default 4, width of the latency counter; SHALL satisfy 2^CNT_W > MUL_LAT.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  an instruction is presented.
REQ-006 SHALL have port ready_o  output  1  block can accept; an issue occurs on an edge where valid_i=1, ready_o=1, flush_i=0.
REQ-007 SHALL have port funct_i  input  6  R-format function field.
REQ-008 SHALL have port ALUOp_i  input  3  main-control ALU op class.
REQ-009 SHALL have port flush_i  input  1  synchronous pipeline flush.
REQ-010 SHALL have port valid_o  output  1  alu_ctrl_o/jr_o are valid this cycle.
REQ-011 SHALL have port ALUCtrl_o  output  4  ALU operation code.
REQ-012 SHALL have port JR_o  output  1  jump-register, asserted only when valid_o=1.
REQ-013 SHALL have port illegal_o  output  1  sticky undecodable-instruction flag.

Function
REQ-014 ALUOp decode SHALL be: 100 R-format (funct lookup), 000 ADD, 101 OR, 111 LUI, 010 SUB, 110 ADD.
REQ-015 Funct decode SHALL be: 32 ADD=0000, 34 SUB=0010, 36 AND=0100, 37 OR=0101, 42 SLT=1010, 43 SLTU=1011, 0 SLL=1101, 4 SLLV=1100, 24 MUL=1000, 8 ADD with JR; ORI=0101, LUI=1111.
REQ-016 Unknown ALUOp or unknown R-format funct SHALL decode as ADD with JR=0 and SHALL be flagged illegal.
REQ-017 FSM states SHALL be IDLE and MUL_WAIT; ready_o=1 exactly when state=IDLE.
REQ-018 Issue of a non-MUL instruction, or of MUL when MUL_LAT=1, SHALL register ALUCtrl_o/JR_o and assert valid_o for one cycle in the cycle after issue (latency 1); state stays IDLE.
REQ-019 Issue of MUL with MUL_LAT>1 SHALL register ALUCtrl_o=1000, load counter with MUL_LAT-1, enter MUL_WAIT.
REQ-020 In MUL_WAIT each edge SHALL decrement the counter; on the edge where counter=1, state SHALL return to IDLE and valid_o SHALL assert for the next cycle; MUL valid_o therefore appears MUL_LAT cycles after issue.
REQ-021 Issue is allowed in the same cycle valid_o of a MUL is high (back-to-back, no bubble).
REQ-022 ALUCtrl_o SHALL hold its last issued value while valid_o=0; JR_o SHALL be 0 whenever valid_o=0.
REQ-023 flush_i=1 SHALL, on the next edge, force state IDLE, counter 0, valid_o 0, JR_o 0; flush SHALL win over a simultaneous valid_i (input dropped) and over a MUL completing that edge.
REQ-024 valid_i while ready_o=0 SHALL be ignored; upstream holds it.

Reset
REQ-025 rst_i=1 SHALL immediately force state IDLE, counter 0, valid_o 0, ALUCtrl_o 0000, JR_o 0, illegal_o 0, regardless of clock; assertion mid-MUL_WAIT abandons the MUL.
REQ-026 ready_o SHALL be 1 during and after reset.

Configuration
REQ-027 Macro ALU_ISSUE_ILLEGAL_TRAP_EN defined: illegal_o SHALL set on the edge of an illegal issue and stay set until rst_i; the illegal instruction still completes as ADD.
REQ-028 Macro ALU_ISSUE_ILLEGAL_TRAP_EN undefined: illegal_o SHALL be constant 0 and no flag register exists; decode per REQ-016 unchanged.

Verification
REQ-029 Reset, then issue ALUOp=100 funct=34 -> next cycle valid_o=1, ALUCtrl_o=0010, JR_o=0, ready_o=1 throughout.
REQ-030 MUL_LAT=4, issue funct=24 at cycle 0 -> ready_o=0 cycles 1-3, valid_o=1 only cycle 4 with ALUCtrl_o=1000; second issue in cycle 4 accepted, its valid_o in cycle 5.
REQ-031 Issue funct=8 -> valid_o=1, ALUCtrl_o=0000, JR_o=1 for one cycle, then JR_o=0 with ALUCtrl_o held.
REQ-032 MUL_LAT=4, MUL issue cycle 0, flush_i=1 with valid_i=1 in cycle 2 -> cycle 3 state IDLE, ready_o=1, valid_o never asserted, flushed input not issued.
REQ-033 rst_i pulsed asynchronously mid-MUL_WAIT -> outputs reset values immediately without a clock edge; no later valid_o.
REQ-034 Macro defined, issue ALUOp=011 -> valid_o with ALUCtrl_o=0000, illegal_o=1 and held until rst_i; macro undefined -> illegal_o=0.
